// File: rtl/trs80_kbd_pkg.sv
// Shared types and constants for the TRS-80 Model I PS/2 keyboard source.
// Holds the PS/2 prefix codes, the decoder state enum and the set-2
// scancode to matrix position lookup.
package trs80_kbd_pkg;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } kbd_state_t;

    typedef struct packed {
        logic       valid;
        logic [2:0] row;
        logic [2:0] col;
    } key_pos_t;

    function automatic key_pos_t mk_pos(input logic [2:0] row, input logic [2:0] col);
        key_pos_t p;
        p.valid = 1'b1;
        p.row   = row;
        p.col   = col;
        return p;
    endfunction

    // ext selects the E0-prefixed table; codes absent from a table are invalid.
    function automatic key_pos_t scancode_to_pos(input logic [7:0] code, input logic ext);
        key_pos_t p;
        p = '0;
        if (ext) begin
            case (code)
                8'h6C:   p = mk_pos(3'd6, 3'd1);   // Home  -> CLEAR
                8'h75:   p = mk_pos(3'd6, 3'd3);   // Up
                8'h72:   p = mk_pos(3'd6, 3'd4);   // Down
                8'h6B:   p = mk_pos(3'd6, 3'd5);   // Left
                8'h74:   p = mk_pos(3'd6, 3'd6);   // Right
                default: p = '0;
            endcase
        end else begin
            case (code)
                8'h54:   p = mk_pos(3'd0, 3'd0);   // @
                8'h1C:   p = mk_pos(3'd0, 3'd1);   // A
                8'h32:   p = mk_pos(3'd0, 3'd2);   // B
                8'h21:   p = mk_pos(3'd0, 3'd3);   // C
                8'h23:   p = mk_pos(3'd0, 3'd4);   // D
                8'h24:   p = mk_pos(3'd0, 3'd5);   // E
                8'h2B:   p = mk_pos(3'd0, 3'd6);   // F
                8'h34:   p = mk_pos(3'd0, 3'd7);   // G
                8'h33:   p = mk_pos(3'd1, 3'd0);   // H
                8'h43:   p = mk_pos(3'd1, 3'd1);   // I
                8'h3B:   p = mk_pos(3'd1, 3'd2);   // J
                8'h42:   p = mk_pos(3'd1, 3'd3);   // K
                8'h4B:   p = mk_pos(3'd1, 3'd4);   // L
                8'h3A:   p = mk_pos(3'd1, 3'd5);   // M
                8'h31:   p = mk_pos(3'd1, 3'd6);   // N
                8'h44:   p = mk_pos(3'd1, 3'd7);   // O
                8'h4D:   p = mk_pos(3'd2, 3'd0);   // P
                8'h15:   p = mk_pos(3'd2, 3'd1);   // Q
                8'h2D:   p = mk_pos(3'd2, 3'd2);   // R
                8'h1B:   p = mk_pos(3'd2, 3'd3);   // S
                8'h2C:   p = mk_pos(3'd2, 3'd4);   // T
                8'h3C:   p = mk_pos(3'd2, 3'd5);   // U
                8'h2A:   p = mk_pos(3'd2, 3'd6);   // V
                8'h1D:   p = mk_pos(3'd2, 3'd7);   // W
                8'h22:   p = mk_pos(3'd3, 3'd0);   // X
                8'h35:   p = mk_pos(3'd3, 3'd1);   // Y
                8'h1A:   p = mk_pos(3'd3, 3'd2);   // Z
                8'h45:   p = mk_pos(3'd4, 3'd0);   // 0
                8'h16:   p = mk_pos(3'd4, 3'd1);   // 1
                8'h1E:   p = mk_pos(3'd4, 3'd2);   // 2
                8'h26:   p = mk_pos(3'd4, 3'd3);   // 3
                8'h25:   p = mk_pos(3'd4, 3'd4);   // 4
                8'h2E:   p = mk_pos(3'd4, 3'd5);   // 5
                8'h36:   p = mk_pos(3'd4, 3'd6);   // 6
                8'h3D:   p = mk_pos(3'd4, 3'd7);   // 7
                8'h3E:   p = mk_pos(3'd5, 3'd0);   // 8
                8'h46:   p = mk_pos(3'd5, 3'd1);   // 9
                8'h52:   p = mk_pos(3'd5, 3'd2);   // :
                8'h4C:   p = mk_pos(3'd5, 3'd3);   // ;
                8'h41:   p = mk_pos(3'd5, 3'd4);   // ,
                8'h4E:   p = mk_pos(3'd5, 3'd5);   // -
                8'h49:   p = mk_pos(3'd5, 3'd6);   // .
                8'h4A:   p = mk_pos(3'd5, 3'd7);   // /
                8'h5A:   p = mk_pos(3'd6, 3'd0);   // ENTER
                8'h76:   p = mk_pos(3'd6, 3'd2);   // Esc   -> BREAK
                8'h29:   p = mk_pos(3'd6, 3'd7);   // SPACE
                8'h12:   p = mk_pos(3'd7, 3'd0);   // left shift
                8'h59:   p = mk_pos(3'd7, 3'd0);   // right shift
                default: p = '0;
            endcase
        end
        return p;
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: two-flop synchronisers, clock glitch filter,
// 11-bit framing with odd-parity check and an inactivity timeout that drops
// partial frames. Emits one byte_valid pulse per good frame.
module ps2_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_valid
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES);

    logic [1:0]    clk_sync;
    logic [1:0]    data_sync;
    logic          filt_clk;
    logic          filt_prev;
    logic [FW-1:0] filt_cnt;
    logic [3:0]    bit_cnt;
    logic [9:0]    shift_q;
    logic [TW-1:0] tmo_cnt;
    logic          fall;
    logic          din;
    logic [10:0]   frame;
    logic          frame_ok;

    assign din      = data_sync[1];
    assign fall     = filt_prev & ~filt_clk;
    assign frame    = {din, shift_q};
    assign frame_ok = ~frame[0] & (^frame[9:1]) & frame[10];

    // Bring both PS/2 lines into the clock domain; idle bus level is high.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    // Accept a new ps2_clk level only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            filt_clk  <= 1'b1;
            filt_prev <= 1'b1;
            filt_cnt  <= '0;
        end else begin
            filt_prev <= filt_clk;
            if (clk_sync[1] != filt_clk) begin
                if (filt_cnt == FILT_LAST) begin
                    filt_clk <= clk_sync[1];
                    filt_cnt <= '0;
                end else begin
                    filt_cnt <= filt_cnt + 1'b1;
                end
            end else begin
                filt_cnt <= '0;
            end
        end
    end

    // Shift in one bit per filtered falling edge; check and publish on the 11th.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            bit_cnt    <= '0;
            shift_q    <= '0;
            tmo_cnt    <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            if (fall) begin
                tmo_cnt <= '0;
                if (bit_cnt == 4'd0) begin
                    // Hunt for a start bit so a lost frame re-aligns cleanly.
                    if (!din) begin
                        shift_q <= {din, shift_q[9:1]};
                        bit_cnt <= 4'd1;
                    end
                end else if (bit_cnt == 4'd10) begin
                    bit_cnt <= '0;
                    if (frame_ok) begin
                        rx_byte    <= frame[8:1];
                        byte_valid <= 1'b1;
                    end
                end else begin
                    shift_q <= {din, shift_q[9:1]};
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end else begin
                if (tmo_cnt != TMO_LAST) begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end else if (bit_cnt != 4'd0) begin
                    bit_cnt <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/ps2_keyboard_matrix.sv
// TRS-80 Model I keyboard source fed by a PS/2 set-2 keyboard.
// Decodes make/break/extended sequences into an 8x8 key matrix and returns
// the OR of the rows addressed by cpu_addr when keyboard_cs_n is low.
// Optional build macro KBD_F12_RESET_EN: F12 make pulses kbd_reset_req for
// one clock instead of being an unmapped code.
//
// state   | meaning
// IDLE    | waiting for a make code or a prefix
// EXT     | E0 seen, next code uses the extended table
// BRK     | F0 seen, next code releases a key
// EXT_BRK | E0 F0 seen, next code releases an extended key
module ps2_keyboard_matrix
    import trs80_kbd_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic [7:0] cpu_addr,
    input  logic       keyboard_cs_n,
    output logic [7:0] keyboard_dout,
    output logic       kbd_reset_req
);

`ifdef KBD_F12_RESET_EN
    localparam logic [7:0] PS2_F12 = 8'h07;
`endif

    logic [7:0]      rx_byte;
    logic            byte_valid;
    kbd_state_t      state;
    logic [7:0][7:0] matrix;
    key_pos_t        norm_pos;
    key_pos_t        ext_pos;
    logic [7:0]      row_or;

    ps2_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clock      (clock),
        .reset_n    (reset_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid)
    );

    assign norm_pos = scancode_to_pos(rx_byte, 1'b0);
    assign ext_pos  = scancode_to_pos(rx_byte, 1'b1);

    // Decoder FSM owning the matrix and the reset-request pulse; steps only on byte_valid.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state         <= IDLE;
            matrix        <= '0;
            kbd_reset_req <= 1'b0;
        end else begin
            kbd_reset_req <= 1'b0;
            if (byte_valid) begin
                case (state)
                    IDLE: begin
                        if (rx_byte == PS2_BREAK) begin
                            state <= BRK;
                        end else if (rx_byte == PS2_EXT) begin
                            state <= EXT;
`ifdef KBD_F12_RESET_EN
                        end else if (rx_byte == PS2_F12) begin
                            kbd_reset_req <= 1'b1;
`endif
                        end else if (norm_pos.valid) begin
                            matrix[norm_pos.row][norm_pos.col] <= 1'b1;
                        end
                    end
                    EXT: begin
                        if (rx_byte == PS2_BREAK) begin
                            state <= EXT_BRK;
                        end else begin
                            if (ext_pos.valid) begin
                                matrix[ext_pos.row][ext_pos.col] <= 1'b1;
                            end
                            state <= IDLE;
                        end
                    end
                    BRK: begin
                        if (norm_pos.valid) begin
                            matrix[norm_pos.row][norm_pos.col] <= 1'b0;
                        end
                        state <= IDLE;
                    end
                    EXT_BRK: begin
                        if (ext_pos.valid) begin
                            matrix[ext_pos.row][ext_pos.col] <= 1'b0;
                        end
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Zero-latency read: OR together every row whose address bit is set.
    always_comb begin
        row_or = '0;
        for (int i = 0; i < 8; i++) begin
            if (cpu_addr[i]) begin
                row_or = row_or | matrix[i];
            end
        end
    end

    assign keyboard_dout = keyboard_cs_n ? 8'h00 : row_or;

endmodule

// File: tb/tb_ps2_keyboard_matrix.sv
// Directed bench for ps2_keyboard_matrix: drives PS/2 frames bit by bit and
// reads the key matrix through the CPU window.
module tb_ps2_keyboard_matrix;

    localparam int TMO  = 1000;
    localparam int HALF = 20;

    logic       clock;
    logic       reset_n;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] cpu_addr;
    logic       keyboard_cs_n;
    logic [7:0] keyboard_dout;
    logic       kbd_reset_req;

    int checks;
    int errors;
    int req_pulses;

    ps2_keyboard_matrix #(
        .FILTER_LEN     (8),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .ps2_clk       (ps2_clk),
        .ps2_data      (ps2_data),
        .cpu_addr      (cpu_addr),
        .keyboard_cs_n (keyboard_cs_n),
        .keyboard_dout (keyboard_dout),
        .kbd_reset_req (kbd_reset_req)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (kbd_reset_req === 1'b1) req_pulses++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic ps2_bit(input logic b);
        wait_clk(HALF / 2);
        ps2_data = b;
        wait_clk(HALF / 2);
        ps2_clk = 1'b0;
        wait_clk(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_bits(input logic [7:0] b, input logic bad_par, input int n);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < n; i++) ps2_bit(f[i]);
        wait_clk(HALF / 2);
        ps2_data = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(b, 1'b0, 11);
        wait_clk(4 * HALF);
    endtask

    task automatic read_kbd(input logic [7:0] a, input logic cs_n, output logic [7:0] v);
        @(negedge clock);
        cpu_addr      = a;
        keyboard_cs_n = cs_n;
        #1;
        v = keyboard_dout;
    endtask

    task automatic test_reset;
        logic [7:0] v;
        read_kbd(8'hFF, 1'b0, v);
        checks++;
        if (v !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h expected 00", v); end
        checks++;
        if (kbd_reset_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", kbd_reset_req); end
    endtask

    task automatic test_make_break;
        logic [7:0] v;
        send_byte(8'h1C);
        read_kbd(8'h01, 1'b0, v);
        checks++;
        if (v !== 8'h02) begin errors++; $display("FAIL make_A: got %h expected 02", v); end
        send_byte(8'hF0); send_byte(8'h1C);
        read_kbd(8'h01, 1'b0, v);
        checks++;
        if (v !== 8'h00) begin errors++; $display("FAIL break_A: got %h expected 00", v); end
    endtask

    task automatic test_multi_row;
        logic [7:0] v;
        send_byte(8'h1C); send_byte(8'h33);
        read_kbd(8'h03, 1'b0, v);
        checks++;
        if (v !== 8'h03) begin errors++; $display("FAIL rows01_or: got %h expected 03", v); end
        read_kbd(8'h02, 1'b0, v);
        checks++;
        if (v !== 8'h01) begin errors++; $display("FAIL row1_H: got %h expected 01", v); end
        read_kbd(8'h03, 1'b1, v);
        checks++;
        if (v !== 8'h00) begin errors++; $display("FAIL cs_n_high: got %h expected 00", v); end
        read_kbd(8'h00, 1'b0, v);
        checks++;
        if (v !== 8'h00) begin errors++; $display("FAIL addr_zero: got %h expected 00", v); end
        send_byte(8'hF0); send_byte(8'h1C);
        send_byte(8'hF0); send_byte(8'h33);
        read_kbd(8'hFF, 1'b0, v);
        checks++;
        if (v !== 8'h00) begin errors++; $display("FAIL multi_release: got %h expected 00", v); end
    endtask

    task automatic test_extended;
        logic [7:0] v;
        send_byte(8'hE0); send_byte(8'h75);
        read_kbd(8'h40, 1'b0, v);
        checks++;
        if (v !== 8'h08) begin errors++; $display("FAIL ext_up_make: got %h expected 08", v); end
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        read_kbd(8'h40, 1'b0, v);
        checks++;
        if (v !== 8'h00) begin errors++; $display("FAIL ext_up_break: got %h expected 00", v); end
        send_byte(8'h75);
        read_kbd(8'hFF, 1'b0, v);
        checks++;
        if (v !== 8'h00) begin errors++; $display("FAIL keypad8_unmapped: got %h expected 00", v); end
        send_byte(8'hE0); send_byte(8'h6C);
        send_byte(8'hE0); send_byte(8'h74);
        read_kbd(8'h40, 1'b0, v);
        checks++;
        if (v !== 8'h42) begin errors++; $display("FAIL ext_clear_right: got %h expected 42", v); end
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h6C);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h74);
        read_kbd(8'h40, 1'b0, v);
        checks++;
        if (v !== 8'h00) begin errors++; $display("FAIL ext_release: got %h expected 00", v); end
    endtask

    task automatic test_parity;
        logic [7:0] v;
        send_bits(8'h1C, 1'b1, 11);
        wait_clk(4 * HALF);
        read_kbd(8'hFF, 1'b0, v);
        checks++;
        if (v !== 8'h00) begin errors++; $display("FAIL bad_parity: got %h expected 00", v); end
        send_byte(8'h29);
        read_kbd(8'h40, 1'b0, v);
        checks++;
        if (v !== 8'h80) begin errors++; $display("FAIL space_after_bad: got %h expected 80", v); end
        send_byte(8'hF0); send_byte(8'h29);
    endtask

    task automatic test_timeout_shift;
        logic [7:0] v;
        send_bits(8'h1C, 1'b0, 6);
        wait_clk(TMO + 10);
        send_byte(8'h12);
        read_kbd(8'h80, 1'b0, v);
        checks++;
        if (v !== 8'h01) begin errors++; $display("FAIL timeout_shift: got %h expected 01", v); end
        send_byte(8'h59);
        send_byte(8'hF0); send_byte(8'h59);
        read_kbd(8'h80, 1'b0, v);
        checks++;
        if (v !== 8'h00) begin errors++; $display("FAIL shift_either_break: got %h expected 00", v); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] v;
        send_byte(8'h45); send_byte(8'h16); send_byte(8'h1E); send_byte(8'h26);
        send_byte(8'h3E); send_byte(8'h4A);
        read_kbd(8'h10, 1'b0, v);
        checks++;
        if (v !== 8'h0F) begin errors++; $display("FAIL digits_row4: got %h expected 0F", v); end
        read_kbd(8'h20, 1'b0, v);
        checks++;
        if (v !== 8'h81) begin errors++; $display("FAIL row5_8_slash: got %h expected 81", v); end
        read_kbd(8'h30, 1'b0, v);
        checks++;
        if (v !== 8'h8F) begin errors++; $display("FAIL rows45_or: got %h expected 8F", v); end
        send_byte(8'hF0); send_byte(8'h45); send_byte(8'hF0); send_byte(8'h16);
        send_byte(8'hF0); send_byte(8'h1E); send_byte(8'hF0); send_byte(8'h26);
        send_byte(8'hF0); send_byte(8'h3E); send_byte(8'hF0); send_byte(8'h4A);
        read_kbd(8'hFF, 1'b0, v);
        checks++;
        if (v !== 8'h00) begin errors++; $display("FAIL b2b_release: got %h expected 00", v); end
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] v;
        send_byte(8'h1C);
        send_byte(8'hF0);
        send_bits(8'h33, 1'b0, 5);
        @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        read_kbd(8'hFF, 1'b0, v);
        checks++;
        if (v !== 8'h00) begin errors++; $display("FAIL midframe_reset_clear: got %h expected 00", v); end
        checks++;
        if (kbd_reset_req !== 1'b0) begin errors++; $display("FAIL midframe_reset_req: got %b expected 0", kbd_reset_req); end
        wait_clk(4 * HALF);
        send_byte(8'h1C);
        read_kbd(8'h01, 1'b0, v);
        checks++;
        if (v !== 8'h02) begin errors++; $display("FAIL fsm_idle_after_reset: got %h expected 02", v); end
        send_byte(8'hF0); send_byte(8'h1C);
    endtask

    task automatic test_f12;
        logic [7:0] v;
        int exp_pulses;
`ifdef KBD_F12_RESET_EN
        exp_pulses = 1;
`else
        exp_pulses = 0;
`endif
        req_pulses = 0;
        send_byte(8'h07);
        checks++;
        if (req_pulses !== exp_pulses) begin errors++; $display("FAIL f12_pulse: got %0d cycles expected %0d", req_pulses, exp_pulses); end
        read_kbd(8'hFF, 1'b0, v);
        checks++;
        if (v !== 8'h00) begin errors++; $display("FAIL f12_matrix: got %h expected 00", v); end
        send_byte(8'hF0); send_byte(8'h07);
        send_byte(8'h1C);
        read_kbd(8'h01, 1'b0, v);
        checks++;
        if (v !== 8'h02 || req_pulses !== exp_pulses) begin
            errors++;
            $display("FAIL f12_break_silent: got %h/%0d expected 02/%0d", v, req_pulses, exp_pulses);
        end
        send_byte(8'hF0); send_byte(8'h1C);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        req_pulses    = 0;
        reset_n       = 1'b0;
        ps2_clk       = 1'b1;
        ps2_data      = 1'b1;
        cpu_addr      = 8'h00;
        keyboard_cs_n = 1'b1;
        wait_clk(3);
        reset_n = 1'b1;
        wait_clk(2);
        test_reset;
        test_make_break;
        test_multi_row;
        test_extended;
        test_parity;
        test_timeout_shift;
        test_back_to_back;
        test_reset_mid_frame;
        test_f12;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_keyboard_matrix.md
Name: ps2_keyboard_matrix

Overview:
- Keyboard source for the TRS-80 Model I memory map.
- Receives PS/2 set-2 scancodes and maintains an 8x8 TRS-80 key matrix of registered key states.
- Returns the row-OR byte for the $3800-$3BFF window to the glue read-data mux, qualified by keyboard_cs_n.

Parameters:
- FILTER_LEN, 8: consecutive identical samples needed before the ps2_clk level is accepted.
- TIMEOUT_CYCLES, 50000: clocks without a ps2_clk falling edge before a partial frame is discarded.

Ports:
- clock  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- ps2_clk  in  1  raw PS/2 clock, asynchronous
- ps2_data  in  1  raw PS/2 data, asynchronous
- cpu_addr  in  8  CPU address bits [7:0]; each set bit selects a matrix row
- keyboard_cs_n  in  1  active-low select from glue
- keyboard_dout  out  8  key byte, 1 = pressed
- kbd_reset_req  out  1  one-clock pulse requesting machine reset (see Optional Feature)

Behaviour:
- Reset: when reset_n=0 at a clock edge, the following clear, and all outputs read 0 from the next edge:
  - all 64 matrix bits;
  - receiver bit count, shift register and timeout counter;
  - decoder FSM to IDLE;
  - kbd_reset_req.
- Input sync:
  - ps2_clk and ps2_data each pass through 2 flops.
  - Filtered clock changes only after FILTER_LEN equal synced samples.
  - Data is sampled on a filtered-clock 1->0 transition.
- Frame format, 11 bits: start=0, data D0..D7 LSB first, odd parity, stop=1.
  - A byte is valid only if start=0, parity is odd over data+parity, and stop=1.
  - On a valid byte, byte_valid pulses for 1 clock. Otherwise the frame is silently dropped.
- Timeout: timeout counter counts clocks since the last falling edge.
  - Reaching TIMEOUT_CYCLES with bit count != 0 returns bit count to 0.
  - The counter saturates.
- Decoder FSM, advanced on byte_valid only:
  - IDLE: F0 -> BRK; E0 -> EXT; E1 and unmapped codes are ignored (stay IDLE); mapped code -> set bit.
  - EXT: F0 -> EXT_BRK; code -> set extended-mapped bit, then IDLE.
  - BRK: code -> clear bit, then IDLE.
  - EXT_BRK: code -> clear extended-mapped bit, then IDLE.
  - Unmapped codes in EXT, BRK or EXT_BRK return to IDLE with no matrix change.
- Map, written as row.bit:
  - Row 0: @=54 at 0.0; A..G at 0.1-0.7.
  - Rows 1-3: H..W and X,Y,Z at rows 1-3 in TRS-80 order.
  - Row 4: digits 0-7 at 4.0-4.7.
  - Row 5: 8, 9, ':'(52), ';'(4C), ','(41), '-'(4E), '.'(49), '/'(4A) at 5.0-5.7.
  - Row 6, all at 6.x:
    - ENTER=5A at 6.0; CLEAR=E0 6C (Home) at 6.1; BREAK=76 (Esc) at 6.2;
    - UP=E0 75 at 6.3; DOWN=E0 72 at 6.4; LEFT=E0 6B at 6.5;
    - RIGHT=E0 74 at 6.6; SPACE=29 at 6.7.
  - Row 7: SHIFT at 7.0, driven by 12 or 59 (either shift key sets it; a break of either clears it).
- Read path, combinational from registered matrix state (zero-latency):
  - keyboard_dout = OR of row[i] for every i where cpu_addr[i]=1.
  - cpu_addr=0 gives 0.
  - keyboard_cs_n=1 forces keyboard_dout=0.
- Simultaneous events: a matrix update and a CPU read in the same cycle return the pre-edge value; the update is visible the next cycle.
- Reset mid-frame: the partial frame is lost; receiving resumes with the next start bit.

Optional Feature:
- Macro: KBD_F12_RESET_EN.
- Defined: in IDLE, a byte_valid of 07 (F12 make) pulses kbd_reset_req for exactly 1 clock. F12 does not touch the matrix. The F12 break is consumed silently.
- Undefined: kbd_reset_req is tied 0 and 07 is an unmapped code.

Decomposition:
- Package trs80_kbd_pkg holds:
  - prefix constants PS2_BREAK=F0 and PS2_EXT=E0;
  - FSM state enum {IDLE, EXT, BRK, EXT_BRK};
  - a row/bit key-position struct with a valid flag.
- Sub-module ps2_rx: sync, filter, framing, parity and timeout. Output: byte[7:0] plus byte_valid.
- Scancode-to-position lookup is a combinational function in the package.

Test Plan:
- Send 1C; read cpu_addr=01, cs_n=0 -> 02. Send F0 1C -> 00.
- Hold A (1C) and H (33); read cpu_addr=03 -> 03; read cpu_addr=02 -> 01; set cs_n=1 -> 00.
- Send E0 75 -> cpu_addr=40 reads 08. Send E0 F0 75 -> 00. Send 75 without prefix (keypad 8) -> unmapped, 40 reads 00.
- Frame 1C with even parity -> matrix unchanged. Then send a valid 29 -> cpu_addr=40 reads 80.
- Send 6 bits of a frame, idle for TIMEOUT_CYCLES+10, then a valid 12 -> cpu_addr=80 reads 01. Assert reset_n=0 for 1 clock mid-frame -> all reads 00 and the FSM is back in IDLE.
- With KBD_F12_RESET_EN: send 07 -> kbd_reset_req is high for exactly 1 clock and the matrix is unchanged. Without the macro: kbd_reset_req stays 0.
